// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops and bit-serial shifts
// that advance one bit per clock.
module alu_multicycle #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         ALUCtrl_i,
    input  logic [WIDTH-1:0]   data1_i,
    input  logic [WIDTH-1:0]   data2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               zero_o
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_count;
    shift_t               r_shop;
    logic [WIDTH-1:0]     r_data;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [SHAMT_W-1:0]   w_count_nxt;
    shift_t               w_shop_nxt;
    logic [WIDTH-1:0]     w_data_nxt;
    logic                 w_done_nxt;

    logic [WIDTH-1:0]     w_alu;
    logic                 w_slt;
    logic                 w_is_shift;
    shift_t               w_shop_dec;
    logic [WIDTH-1:0]     w_acc_shifted;

    // Single-cycle result; shift codes fall to ADD but are never selected here.
    always_comb begin
        w_slt = ($signed(data1_i) < $signed(data2_i));
        case (ALUCtrl_i)
            OP_SUB:  w_alu = data1_i - data2_i;
            OP_AND:  w_alu = data1_i & data2_i;
            OP_OR:   w_alu = data1_i | data2_i;
            OP_XOR:  w_alu = data1_i ^ data2_i;
            OP_SLT:  w_alu = WIDTH'(w_slt);
            default: w_alu = data1_i + data2_i;
        endcase
    end

    // Classify the request and pick the shift flavour.
    always_comb begin
        w_is_shift = 1'b0;
        w_shop_dec = SH_SRA;
        case (ALUCtrl_i)
            OP_SLL: begin
                w_is_shift = 1'b1;
                w_shop_dec = SH_SLL;
            end
            OP_SRL: begin
                w_is_shift = 1'b1;
                w_shop_dec = SH_SRL;
            end
            OP_SRA: begin
                w_is_shift = 1'b1;
                w_shop_dec = SH_SRA;
            end
            default: begin
                w_is_shift = 1'b0;
                w_shop_dec = SH_SRA;
            end
        endcase
    end

    // One-bit step of the accumulator.
    always_comb begin
        case (r_shop)
            SH_SLL:  w_acc_shifted = {r_acc[WIDTH-2:0], 1'b0};
            SH_SRL:  w_acc_shifted = {1'b0, r_acc[WIDTH-1:1]};
            default: w_acc_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_shop_nxt  = r_shop;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        if (r_state == S_IDLE) begin
            if (start_i) begin
                if (w_is_shift) begin
                    w_state_nxt = S_SHIFT;
                    w_acc_nxt   = data1_i;
                    w_count_nxt = data2_i[SHAMT_W-1:0];
                    w_shop_nxt  = w_shop_dec;
                end else begin
                    w_data_nxt = w_alu;
                    w_done_nxt = 1'b1;
                end
            end
        end else begin
            if (r_count != '0) begin
                w_acc_nxt   = w_acc_shifted;
                w_count_nxt = r_count - SHAMT_W'(1);
            end else begin
                w_data_nxt  = r_acc;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_shop  <= SH_SLL;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_shop  <= w_shop_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy_o = (r_state == S_SHIFT);
    assign done_o = r_done;
    assign data_o = r_data;
    assign zero_o = (r_data == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: result-level model plus directed literal checks.
module tb_alu_multicycle;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR_ = 4'b0001;
    localparam logic [3:0] XOR = 4'b0011;
    localparam logic [3:0] SLT = 4'b1000;
    localparam logic [3:0] SLL = 4'b1001;
    localparam logic [3:0] SRL = 4'b1010;
    localparam logic [3:0] SRA = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .data_o    (data_o),
        .zero_o    (zero_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Result of an operation as plain arithmetic.
    function automatic logic [31:0] f_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            SUB:     return a - b;
            AND:     return a & b;
            OR_:     return a | b;
            XOR:     return a ^ b;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLL:     return a << b[4:0];
            SRL:     return a >> b[4:0];
            SRA:     return 32'($signed(a) >>> b[4:0]);
            default: return a + b;
        endcase
    endfunction

    function automatic bit f_is_shift(input logic [3:0] c);
        return (c == SLL) || (c == SRL) || (c == SRA);
    endfunction

    // Model: cycles remaining until a shift result appears, plus current outputs.
    int          m_left;
    logic [31:0] m_pend;
    logic [31:0] m_data;
    logic        m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_pend = '0;
            m_data = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_data = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (f_is_shift(ctrl)) begin
                    m_pend = f_alu(ctrl, d1, d2);
                    m_left = int'(d2[4:0]) + 1;
                end else begin
                    m_data = f_alu(ctrl, d1, d2);
                    m_done = 1'b1;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("m_done", 32'(done_o), 32'(m_done));
        chk("m_data", data_o, m_data);
        chk("m_busy", 32'(busy_o), 32'(m_left > 0));
        chk("m_zero", 32'(zero_o), 32'(m_data == 32'd0));
    end

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        ctrl  = c;
        d1    = a;
        d2    = b;
        @(negedge clk);
    endtask

    // Issue a shift, wait for done, report edges (acceptance edge = 1) and busy cycles.
    task automatic run_shift(input string name, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input int exp_edges, input logic [31:0] exp_data,
                             output int busy_n);
        int edges;
        drive(c, a, b);
        start  = 1'b0;
        edges  = 1;
        busy_n = 0;
        while (!done_o && edges < 64) begin
            if (busy_o) busy_n++;
            @(negedge clk);
            edges++;
        end
        chk({name, "_lat"}, 32'(edges), 32'(exp_edges));
        chk({name, "_data"}, data_o, exp_data);
    endtask

    initial begin
        int busy_n;
        int dones;
        rst   = 1'b0;
        start = 1'b0;
        ctrl  = 4'b0000;
        d1    = '0;
        d2    = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back single-cycle ops.
        drive(ADD, 32'h7FFF_FFFF, 32'd1);
        chk("add_data", data_o, 32'h8000_0000);
        chk("add_zero", 32'(zero_o), 32'd0);
        chk("add_done", 32'(done_o), 32'd1);
        drive(SUB, 32'd5, 32'd5);
        chk("sub_data", data_o, 32'h0);
        chk("sub_zero", 32'(zero_o), 32'd1);
        chk("sub_done", 32'(done_o), 32'd1);
        drive(SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg", data_o, 32'd1);
        drive(SLT, 32'd1, 32'hFFFF_FFFF);
        chk("slt_pos", data_o, 32'd0);
        drive(4'b1111, 32'd3, 32'd4);
        chk("bad_code", data_o, 32'd7);
        drive(AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and", data_o, 32'hF000_F000);
        drive(OR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("or", data_o, 32'hFFF0_FFF0);
        drive(XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("xor", data_o, 32'h0FF0_0FF0);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", 32'(done_o), 32'd0);
        chk("data_hold", data_o, 32'h0FF0_0FF0);

        // Long shifts.
        run_shift("sra31", SRA, 32'h8000_0000, 32'd31, 33, 32'hFFFF_FFFF, busy_n);
        chk("sra31_busy", 32'(busy_n), 32'd32);
        run_shift("srl31", SRL, 32'h8000_0000, 32'd31, 33, 32'h0000_0001, busy_n);
        chk("srl31_busy", 32'(busy_n), 32'd32);
        run_shift("sll0", SLL, 32'h1, 32'd0, 2, 32'h1, busy_n);
        chk("sll0_busy", 32'(busy_n), 32'd1);

        // Issued in the done cycle of the previous shift; start/operands poked while busy.
        drive(SLL, 32'h1, 32'd4);
        dones = 0;
        for (int i = 1; i <= 10; i++) begin
            if (done_o) begin
                dones++;
                chk("sll4_lat", 32'(i), 32'd6);
                chk("sll4_data", data_o, 32'h10);
            end
            if (i == 2) begin
                start = 1'b1;
                ctrl  = ADD;
                d1    = 32'd9;
                d2    = 32'd9;
            end else begin
                start = 1'b0;
                if (i == 3) begin
                    ctrl = SRA;
                    d1   = 32'hDEAD_BEEF;
                    d2   = 32'd7;
                end
            end
            @(negedge clk);
        end
        chk("sll4_dones", 32'(dones), 32'd1);

        // Asynchronous reset in the middle of a shift.
        drive(SLL, 32'h3, 32'd10);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk("arst_data", data_o, 32'd0);
        chk("arst_zero", 32'(zero_o), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        drive(ADD, 32'd2, 32'd3);
        chk("post_rst_add", data_o, 32'd5);
        start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
